// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshake, status flags, shifts and
// an iterative shift-add multiply. The output register is the EX/MEM boundary.
module alu_pipe #(
  parameter int unsigned WIDTH      = 64,
  parameter bit          ENABLE_MUL = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       C,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] R,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             illegal,
  output logic             busy
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned PW  = 2 * WIDTH;
  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1111;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t           state;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    acc;
  logic [SHW-1:0]   count;

  logic             accept;
  logic             consume;
  logic             is_mul;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [SHW-1:0]   shamt;
  logic             slt;
  logic [WIDTH-1:0] op_r;
  logic             op_c;
  logic             op_v;
  logic             op_ill;
  logic [PW-1:0]    mul_add;

  // Handshake: only take new work when idle and the output register can be refilled
  always_comb begin
    in_ready = !reset && (state == S_IDLE) && (!out_valid || out_ready);
    accept   = in_valid && in_ready;
    consume  = out_valid && out_ready;
    is_mul   = (C == OP_MUL) && (ENABLE_MUL == 1'b1);
  end

  // Shared arithmetic terms for the single-cycle ops
  always_comb begin
    add_full = {1'b0, A} + {1'b0, B};
    sub_full = {1'b0, A} - {1'b0, B};
    shamt    = B[SHW-1:0];
    slt      = $signed(A) < $signed(B);
  end

  // Single-cycle result and flags; undefined opcodes (incl. MUL when disabled) flag illegal
  always_comb begin
    op_r   = '0;
    op_c   = 1'b0;
    op_v   = 1'b0;
    op_ill = 1'b0;
    case (C)
      OP_AND: op_r = A & B;
      OP_OR:  op_r = A | B;
      OP_XOR: op_r = A ^ B;
      OP_NOR: op_r = ~(A | B);
      OP_ADD: begin
        op_r = add_full[WIDTH-1:0];
        op_c = add_full[WIDTH];
        op_v = (A[MSB] == B[MSB]) && (add_full[MSB] != A[MSB]);
      end
      OP_SUB: begin
        op_r = sub_full[WIDTH-1:0];
        op_c = !sub_full[WIDTH];
        op_v = (A[MSB] != B[MSB]) && (sub_full[MSB] != A[MSB]);
      end
      OP_SLT: op_r = WIDTH'(slt);
      OP_SLL: op_r = A << shamt;
      OP_SRL: op_r = A >> shamt;
      OP_SRA: op_r = $signed(A) >>> shamt;
      default: op_ill = 1'b1;
    endcase
  end

  // One shift-add step: conditionally add the multiplicand into the accumulator
  always_comb begin
    mul_add = acc + (mplier[0] ? mcand : '0);
  end

  // Multiply FSM, operand capture and the output register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      R         <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && is_mul) begin
            state     <= S_MUL;
            mcand     <= {{WIDTH{1'b0}}, A};
            mplier    <= B;
            acc       <= '0;
            count     <= SHW'(WIDTH - 1);
            busy      <= 1'b1;
            out_valid <= 1'b0;
          end else if (accept) begin
            R         <= op_r;
            zero      <= (op_r == '0);
            carry     <= op_c;
            overflow  <= op_v;
            illegal   <= op_ill;
            out_valid <= 1'b1;
          end else if (consume) begin
            out_valid <= 1'b0;
          end
        end
        S_MUL: begin
          acc    <= mul_add;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - 1'b1;
          if (count == '0) begin
            R         <= mul_add[WIDTH-1:0];
            zero      <= (mul_add[WIDTH-1:0] == '0);
            carry     <= 1'b0;
            overflow  <= |mul_add[PW-1:WIDTH];
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed corner cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_alu_pipe;

  localparam int unsigned W = 64;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   C;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] R;
  logic         zero, carry, overflow, illegal, busy;

  logic         nm_in_valid;
  logic         nm_in_ready;
  logic         nm_out_valid;
  logic         nm_out_ready;
  logic [W-1:0] nm_R;
  logic         nm_zero, nm_carry, nm_overflow, nm_illegal, nm_busy;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  alu_pipe #(.WIDTH(W), .ENABLE_MUL(1'b1)) u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .C(C), .out_valid(out_valid), .out_ready(out_ready),
    .R(R), .zero(zero), .carry(carry), .overflow(overflow),
    .illegal(illegal), .busy(busy)
  );

  alu_pipe #(.WIDTH(W), .ENABLE_MUL(1'b0)) u_nomul (
    .clock(clock), .reset(reset), .in_valid(nm_in_valid), .in_ready(nm_in_ready),
    .A(A), .B(B), .C(C), .out_valid(nm_out_valid), .out_ready(nm_out_ready),
    .R(nm_R), .zero(nm_zero), .carry(nm_carry), .overflow(nm_overflow),
    .illegal(nm_illegal), .busy(nm_busy)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model straight from the opcode definitions
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [3:0] c, input bit mul_en,
                                output logic [W-1:0] r, output logic cy,
                                output logic ov, output logic il);
    logic [2*W-1:0]  p;
    logic signed [W+1:0] sa, sb, sr;
    int sh;
    p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    sa = (W+2)'($signed(a));
    sb = (W+2)'($signed(b));
    sh = int'(b[5:0]);
    r = '0; cy = 1'b0; ov = 1'b0; il = 1'b0;
    case (c)
      4'h0: r = a & b;
      4'h1: r = a | b;
      4'h3: r = a ^ b;
      4'hC: r = ~(a | b);
      4'h2: begin
        r  = a + b;
        cy = (r < a);
        sr = (W+2)'($signed(r));
        ov = ((sa + sb) != sr);
      end
      4'h6: begin
        r  = a - b;
        cy = (a >= b);
        sr = (W+2)'($signed(r));
        ov = ((sa - sb) != sr);
      end
      4'h7: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'h8: r = a << sh;
      4'h9: r = a >> sh;
      4'hA: begin
        r = a >> sh;
        if (a[W-1]) r = r | ~({W{1'b1}} >> sh);
      end
      4'hF: begin
        if (mul_en) begin
          r  = p[W-1:0];
          ov = (p[2*W-1:W] != '0);
        end else begin
          il = 1'b1;
        end
      end
      default: il = 1'b1;
    endcase
  endfunction

  // Present an op, wait (bounded) for acceptance, then scramble the inputs
  task automatic accept_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c);
    int n;
    in_valid = 1'b1; A = a; B = b; C = c;
    n = 0;
    while (in_ready !== 1'b1 && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk("accept_wait", 64'(in_ready), 64'd1);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    A = {$urandom, $urandom};
    B = {$urandom, $urandom};
    C = 4'($urandom);
  endtask

  // Wait for the result (multiply latency checked) and compare against the model
  task automatic result_check(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c);
    logic [W-1:0] er;
    logic ec, ev, ei;
    int edges;
    model(a, b, c, 1'b1, er, ec, ev, ei);
    if (c == 4'hF) begin
      edges = 0;
      while (out_valid !== 1'b1 && edges < 200) begin
        chk("mul_busy", 64'(busy), 64'd1);
        chk("mul_in_ready", 64'(in_ready), 64'd0);
        @(posedge clock);
        @(negedge clock);
        edges++;
      end
      chk("mul_latency", 64'(edges), 64'(W));
    end
    chk("out_valid", 64'(out_valid), 64'd1);
    chk("R", R, er);
    chk("zero", 64'(zero), 64'(er == '0));
    chk("carry", 64'(carry), 64'(ec));
    chk("overflow", 64'(overflow), 64'(ev));
    chk("illegal", 64'(illegal), 64'(ei));
    chk("busy_done", 64'(busy), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic [3:0]   rc;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    nm_in_valid = 1'b0; nm_out_ready = 1'b1;
    A = '0; B = '0; C = '0;

    // reset state
    @(negedge clock);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_R", R, 64'd0);
    chk("rst_flags", 64'({zero, carry, overflow, illegal, busy}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    #1 chk("rel_in_ready", 64'(in_ready), 64'd1);
    @(negedge clock);

    // back-to-back single-cycle ops
    accept_op(64'd5, 64'd5, 4'h2);  result_check(64'd5, 64'd5, 4'h2);
    accept_op(64'd10, 64'd10, 4'h1); result_check(64'd10, 64'd10, 4'h1);
    chk("b2b_R", R, 64'd10);

    accept_op(64'd27, 64'd43, 4'h6); result_check(64'd27, 64'd43, 4'h6);
    chk("sub_R", R, 64'hFFFF_FFFF_FFFF_FFF0);
    accept_op(64'd27, 64'd43, 4'h7); result_check(64'd27, 64'd43, 4'h7);
    chk("slt_lt", R, 64'd1);
    accept_op(64'd43, 64'd27, 4'h7); result_check(64'd43, 64'd27, 4'h7);
    chk("slt_ge_zero", 64'(zero), 64'd1);
    accept_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'h2);
    result_check(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'h2);
    chk("add_ovf", 64'(overflow), 64'd1);
    accept_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'h2);
    result_check(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'h2);
    chk("add_carry", 64'(carry), 64'd1);
    accept_op(64'h8000_0000_0000_1234, 64'hFF00, 4'hA);
    result_check(64'h8000_0000_0000_1234, 64'hFF00, 4'hA);
    chk("shift0", R, 64'h8000_0000_0000_1234);
    accept_op(64'h8000_0000_0000_0000, 64'd63, 4'hA);
    result_check(64'h8000_0000_0000_0000, 64'd63, 4'hA);
    chk("sra_fill", R, 64'hFFFF_FFFF_FFFF_FFFF);

    // multiply
    accept_op(64'd27, 64'd43, 4'hF); result_check(64'd27, 64'd43, 4'hF);
    chk("mul_R", R, 64'd1161);
    accept_op(64'h1_0000_0000, 64'h1_0000_0000, 4'hF);
    result_check(64'h1_0000_0000, 64'h1_0000_0000, 4'hF);
    chk("mul_hi_ovf", 64'(overflow), 64'd1);

    // illegal opcode
    accept_op(64'd9, 64'd9, 4'h4); result_check(64'd9, 64'd9, 4'h4);

    // backpressure: result held, pending op waits, then consume+accept together
    @(negedge clock);
    out_ready = 1'b0;
    accept_op(64'd1, 64'd2, 4'h2); result_check(64'd1, 64'd2, 4'h2);
    in_valid = 1'b1; A = 64'd9; B = 64'd4; C = 4'h6;
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_R", R, 64'd3);
      chk("stall_valid", 64'(out_valid), 64'd1);
      @(negedge clock);
    end
    out_ready = 1'b1;
    #1 chk("unstall_in_ready", 64'(in_ready), 64'd1);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    result_check(64'd9, 64'd4, 4'h6);
    chk("unstall_R", R, 64'd5);

    // asynchronous reset mid-multiply
    accept_op(64'd1234, 64'd5678, 4'hF);
    repeat (10) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_R", R, 64'd0);
    chk("arst_flags", 64'({zero, carry, overflow, illegal}), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("arst_rel_in_ready", 64'(in_ready), 64'd1);
    chk("arst_rel_valid", 64'(out_valid), 64'd0);

    // multiply disabled: 1111 is illegal and single-cycle
    nm_in_valid = 1'b1; A = 64'd3; B = 64'd5; C = 4'hF;
    #1 chk("nm_in_ready", 64'(nm_in_ready), 64'd1);
    @(posedge clock);
    @(negedge clock);
    nm_in_valid = 1'b0;
    chk("nm_valid", 64'(nm_out_valid), 64'd1);
    chk("nm_illegal", 64'(nm_illegal), 64'd1);
    chk("nm_busy", 64'(nm_busy), 64'd0);
    chk("nm_R", nm_R, 64'd0);
    chk("nm_zero", 64'(nm_zero), 64'd1);

    // random ops
    for (int i = 0; i < 60; i++) begin
      rc = 4'($urandom_range(0, 15));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rb = 64'($urandom_range(0, 70));
      if ($urandom_range(0, 5) == 0) ra = 64'($urandom_range(0, 70));
      accept_op(ra, rb, rc);
      result_check(ra, rb, rc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
